// File: rtl/alu_pkg.sv
// Shared opcode constants and legality check for the ALU issue path.
// Used by alu_issue_stage and alu_fwd_mux.
package alu_pkg;

    localparam logic [3:0] OPC_ADD = 4'd0;
    localparam logic [3:0] OPC_SUB = 4'd1;
    localparam logic [3:0] OPC_SLT = 4'd2;
    localparam logic [3:0] OPC_OR  = 4'd3;
    localparam logic [3:0] OPC_AND = 4'd4;
    localparam logic [3:0] OPC_SLL = 4'd5;
    localparam logic [3:0] OPC_SEQ = 4'd9;

    function automatic logic opc_legal(input logic [3:0] opc);
        case (opc)
            OPC_ADD, OPC_SUB, OPC_SLT, OPC_OR,
            OPC_AND, OPC_SLL, OPC_SEQ: opc_legal = 1'b1;
            default:                   opc_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// Operand select: r0 reads as zero, writeback hit wins over register data.
// Writeback forwarding is present only when ALU_FWD_EN is defined.
module alu_fwd_mux
    import alu_pkg::*;
#(
    parameter int DW  = 16,
    parameter int RAW = 3
) (
    input  logic [RAW-1:0] src_i,
    input  logic [DW-1:0]  rdata_i,
    input  logic           wb_valid_i,
    input  logic [RAW-1:0] wb_addr_i,
    input  logic [DW-1:0]  wb_data_i,
    output logic [DW-1:0]  opnd_o
);

`ifdef ALU_FWD_EN
    logic hit;
    assign hit = wb_valid_i && (wb_addr_i == src_i);
    always_comb begin
        opnd_o = rdata_i;
        if (src_i == '0) opnd_o = '0;
        else if (hit)    opnd_o = wb_data_i;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid_i, wb_addr_i, wb_data_i};
    assign opnd_o = (src_i == '0) ? '0 : rdata_i;
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// Two-entry issue buffer feeding the ALU, with optional writeback
// forwarding into buffered operands (ALU_FWD_EN).
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DW    = 16,
    parameter int RAW   = 3,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     in_opc,
    input  logic [RAW-1:0] in_rs1,
    input  logic [RAW-1:0] in_rs2,
    input  logic [DW-1:0]  in_rs1_data,
    input  logic [DW-1:0]  in_rs2_data,
    input  logic           in_use_imm,
    input  logic [DW-1:0]  in_imm,
    input  logic [RAW-1:0] in_rd,
    input  logic           wb_valid,
    input  logic [RAW-1:0] wb_addr,
    input  logic [DW-1:0]  wb_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_a,
    output logic [DW-1:0]  out_b,
    output logic [3:0]     out_opc,
    output logic [RAW-1:0] out_rd,
    output logic           out_illegal
);

    logic [DW-1:0]  a_q[2], a_d[2], b_q[2], b_d[2];
    logic [3:0]     opc_q[2], opc_d[2];
    logic [RAW-1:0] rd_q[2], rd_d[2];
    logic [RAW-1:0] rs1_q[2], rs1_d[2], rs2_q[2], rs2_d[2];
    logic           imm_q[2], imm_d[2];
    logic           wp_q, wp_d, rp_q, rp_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [DW-1:0]  oa_q, oa_d, ob_q, ob_d;
    logic [3:0]     oopc_q, oopc_d;
    logic [RAW-1:0] ord_q, ord_d;
    logic [DW-1:0]  cap_a, cap_b;
    logic [DW-1:0]  ea[2], eb[2];
    logic           push, pop;

    assign in_ready    = (cnt_q != 2'(DEPTH));
    assign out_valid   = (cnt_q != 2'd0);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign out_a       = oa_q;
    assign out_b       = ob_q;
    assign out_opc     = oopc_q;
    assign out_rd      = ord_q;
    assign out_illegal = ~opc_legal(oopc_q);

    alu_fwd_mux #(.DW(DW), .RAW(RAW)) u_cap_a (
        .src_i(in_rs1), .rdata_i(in_rs1_data),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr),
        .wb_data_i(wb_data), .opnd_o(cap_a)
    );

    alu_fwd_mux #(.DW(DW), .RAW(RAW)) u_cap_b (
        .src_i(in_rs2), .rdata_i(in_rs2_data),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr),
        .wb_data_i(wb_data), .opnd_o(cap_b)
    );

    for (genvar i = 0; i < 2; i++) begin : g_ent
        alu_fwd_mux #(.DW(DW), .RAW(RAW)) u_ea (
            .src_i(rs1_q[i]), .rdata_i(a_q[i]),
            .wb_valid_i(wb_valid), .wb_addr_i(wb_addr),
            .wb_data_i(wb_data), .opnd_o(ea[i])
        );
        alu_fwd_mux #(.DW(DW), .RAW(RAW)) u_eb (
            .src_i(rs2_q[i]), .rdata_i(b_q[i]),
            .wb_valid_i(wb_valid), .wb_addr_i(wb_addr),
            .wb_data_i(wb_data), .opnd_o(eb[i])
        );
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            a_d[i]   = ea[i];
            b_d[i]   = imm_q[i] ? b_q[i] : eb[i];
            opc_d[i] = opc_q[i];
            rd_d[i]  = rd_q[i];
            rs1_d[i] = rs1_q[i];
            rs2_d[i] = rs2_q[i];
            imm_d[i] = imm_q[i];
        end
        wp_d  = wp_q ^ push;
        rp_d  = rp_q ^ pop;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        if (push && !flush) begin
            a_d[wp_q]   = cap_a;
            b_d[wp_q]   = in_use_imm ? in_imm : cap_b;
            opc_d[wp_q] = in_opc;
            rd_d[wp_q]  = in_rd;
            rs1_d[wp_q] = in_rs1;
            rs2_d[wp_q] = in_rs2;
            imm_d[wp_q] = in_use_imm;
        end
        if (flush) begin
            wp_d  = 1'b0;
            rp_d  = 1'b0;
            cnt_d = 2'd0;
        end
        // Outputs track the next head so they are pure registers.
        oa_d   = oa_q;
        ob_d   = ob_q;
        oopc_d = oopc_q;
        ord_d  = ord_q;
        if (cnt_d != 2'd0) begin
            oa_d   = a_d[rp_d];
            ob_d   = b_d[rp_d];
            oopc_d = opc_d[rp_d];
            ord_d  = rd_d[rp_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                opc_q[i] <= '0;
                rd_q[i]  <= '0;
                rs1_q[i] <= '0;
                rs2_q[i] <= '0;
                imm_q[i] <= 1'b0;
            end
            wp_q   <= 1'b0;
            rp_q   <= 1'b0;
            cnt_q  <= 2'd0;
            oa_q   <= '0;
            ob_q   <= '0;
            oopc_q <= '0;
            ord_q  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                a_q[i]   <= a_d[i];
                b_q[i]   <= b_d[i];
                opc_q[i] <= opc_d[i];
                rd_q[i]  <= rd_d[i];
                rs1_q[i] <= rs1_d[i];
                rs2_q[i] <= rs2_d[i];
                imm_q[i] <= imm_d[i];
            end
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            oa_q   <= oa_d;
            ob_q   <= ob_d;
            oopc_q <= oopc_d;
            ord_q  <= ord_d;
        end
    end

endmodule
